pipe_gen: RTL and testbench
===========================

Name: pipe_gen

Overview:
- Generates the scrolling pipe field for the 16x16 LED-matrix Flappy Bird game.
- Holds 16 columns of 16-bit pipe patterns and shifts them one column toward the bird on every pipe tick.
- Spawns new pipes at column 15, with a pseudo-random gap.
- Column 0 is the bird's column. It drives `pipe` into the collision/score stage. A second read port serves the display scanner.

Parameters:
- GAP_H, 4: gap height in rows. Legal range 3..7.
- PIPE_W, 2: pipe width in columns (ticks). Legal range 1..4.
- SPACING, 6: ticks from one pipe's first column to the next pipe's first column. Must be greater than PIPE_W; maximum 15.
- SEED, 8'hA5: LFSR reset value. Must be nonzero.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-low reset (0 = reset asserted).
- clkP, in, 1: pipe-advance tick. One clk-cycle pulse, synchronous to clk.
- run, in, 1: game running. 0 freezes the field.
- gameover, in, 1: from the collision stage. 1 freezes the field.
- col_sel, in, 4: display column select.
- pipe, out, 16: column 0 pattern; bit i = row i; bit 0 = floor row.
- col_data, out, 16: column[col_sel], combinational read.
- spawn, out, 1: one-cycle pulse on the cycle after a new pipe's first column is loaded.

Behaviour:
- Storage: col[0..15], each 16 bits; pipe = col[0], driven directly from the register with no extra latency.
- Advance condition: adv = clkP & run & ~gameover. Each high clk cycle of adv counts as one tick. No edge detection.
- On adv, shift: col[i] <= col[i+1] for i = 0..14; col[15] <= next column.
- Next column comes from a 2-state FSM:
  - GAP state:
    - If spc_cnt == 0: compute pattern, load col[15] <= pattern, latch pat <= pattern, advance the LFSR, and pulse spawn.
    - Then set w_cnt <= PIPE_W-1. If PIPE_W > 1, go to BODY.
    - Otherwise col[15] <= 0.
    - spc_cnt <= (spc_cnt == SPACING-1) ? 0 : spc_cnt+1 on every tick.
  - BODY state:
    - col[15] <= pat.
    - w_cnt decrements. Return to GAP when w_cnt reaches 1 on this tick.
    - spc_cnt increments as in GAP.
- Gap arithmetic:
  - R = 15 - GAP_H (always >= 8).
  - c = lfsr[3:0]; r = (c >= R) ? c - R : c; gap_lo = 1 + r.
  - pattern = 16'hFFFF with bits gap_lo .. gap_lo+GAP_H-1 cleared.
  - Row 0 and row 15 are always solid inside a pipe column.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - fb = l[7]^l[5]^l[4]^l[3]; next = {l[6:0], fb}.
  - Advances only on a spawn, after its current value has been used.
- Freeze: when run=0 or gameover=1, all registers hold and clkP is ignored. When both are cleared, the field resumes from the held state. A clkP coinciding with gameover=1 is ignored.
- Reset (any time, including mid-pipe):
  - col[*] = 0, pat = 0, spc_cnt = 0, w_cnt = 0, state = GAP, lfsr = SEED, spawn = 0.
  - pipe = 0 and col_data = 0 immediately.
- Consequence: the first tick after reset spawns a pipe at column 15. It reaches column 0 on tick 16.
- spawn is registered and high for exactly one clk cycle per spawn.

Test Plan:
1. Reset, then no ticks -> pipe=0, col_data=0 for all col_sel, spawn=0.
2. Defaults; run=1; gameover=0; one clkP -> spawn pulses once; col_data[sel=15]=16'hFC3F (gap rows 6..9). After 16 ticks, pipe=16'hFC3F on ticks 16 and 17, then 0 on tick 18.
3. Continue ticking -> second spawn at tick 7 with LFSR 8'h4A, giving col[15]=16'h87FF (gap rows 11..14). Spawns recur at ticks 1, 7, 13, 19, ...
4. Mid-field, assert gameover and pulse clkP 5 times -> all col_data and pipe unchanged. Repeat with run=0. Deassert, then one tick -> exactly one shift.
5. Assert reset (low) asynchronously between clk edges while a pipe is in BODY state -> all outputs 0 immediately. On release, the first tick again yields 16'hFC3F.
6. Sweep GAP_H=7 and PIPE_W=1; check LFSR values with c >= R -> gap_lo stays in 1..8, rows 0 and 15 are set, and every pipe column has exactly GAP_H zero bits.

Source files
------------

// File: rtl/pipe_gen.sv
// Scrolling pipe field for the 16x16 Flappy Bird matrix: 16 columns shift toward
// the bird (column 0) on each pipe tick, with new pipes spawned at column 15.
module pipe_gen #(
  parameter int          GAP_H   = 4,
  parameter int          PIPE_W  = 2,
  parameter int          SPACING = 6,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clkP,
  input  logic        run,
  input  logic        gameover,
  input  logic [3:0]  col_sel,
  output logic [15:0] pipe,
  output logic [15:0] col_data,
  output logic        spawn
);

  localparam int R = 15 - GAP_H;

  typedef enum logic {
    ST_GAP  = 1'b0,
    ST_BODY = 1'b1
  } state_t;

  logic [15:0] col_q [16];
  logic [15:0] col_d [16];
  logic [15:0] pat_q, pat_d;
  logic [3:0]  spc_cnt_q, spc_cnt_d;
  logic [2:0]  w_cnt_q, w_cnt_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        spawn_q, spawn_d;
  state_t      state_q, state_d;
  logic        adv_s;
  logic [15:0] new_col_s;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Fold the 4-bit random value into 0..R-1 so the gap never touches rows 0 or 15.
  function automatic logic [15:0] gap_pattern(input logic [7:0] l);
    logic [3:0]  c;
    logic [3:0]  r;
    logic [4:0]  lo;
    logic [15:0] mask;
    c = l[3:0];
    if (c >= 4'(R)) begin
      r = c - 4'(R);
    end else begin
      r = c;
    end
    lo   = {1'b0, r} + 5'd1;
    mask = ((16'd1 << GAP_H) - 16'd1) << lo;
    return ~mask;
  endfunction

  assign adv_s = clkP & run & ~gameover;

  // Next-state: column shift, spawn FSM, spacing/width counters and LFSR.
  always_comb begin
    col_d     = col_q;
    pat_d     = pat_q;
    spc_cnt_d = spc_cnt_q;
    w_cnt_d   = w_cnt_q;
    lfsr_d    = lfsr_q;
    state_d   = state_q;
    spawn_d   = 1'b0;
    new_col_s = 16'h0000;
    if (adv_s) begin
      case (state_q)
        ST_GAP: begin
          if (spc_cnt_q == 4'd0) begin
            new_col_s = gap_pattern(lfsr_q);
            pat_d     = new_col_s;
            lfsr_d    = lfsr_next(lfsr_q);
            spawn_d   = 1'b1;
            w_cnt_d   = 3'(PIPE_W - 1);
            if (PIPE_W > 1) begin
              state_d = ST_BODY;
            end else begin
              state_d = ST_GAP;
            end
          end else begin
            new_col_s = 16'h0000;
          end
        end
        ST_BODY: begin
          new_col_s = pat_q;
          w_cnt_d   = w_cnt_q - 3'd1;
          if (w_cnt_q == 3'd1) begin
            state_d = ST_GAP;
          end else begin
            state_d = ST_BODY;
          end
        end
        default: begin
          new_col_s = 16'h0000;
          state_d   = ST_GAP;
        end
      endcase
      if (spc_cnt_q == 4'(SPACING - 1)) begin
        spc_cnt_d = 4'd0;
      end else begin
        spc_cnt_d = spc_cnt_q + 4'd1;
      end
      for (int i = 0; i < 15; i++) begin
        col_d[i] = col_q[i + 1];
      end
      col_d[15] = new_col_s;
    end else begin
      spawn_d = 1'b0;
    end
  end

  // State registers; reset clears the field and reloads the LFSR seed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) begin
        col_q[i] <= 16'h0000;
      end
      pat_q     <= 16'h0000;
      spc_cnt_q <= 4'd0;
      w_cnt_q   <= 3'd0;
      lfsr_q    <= SEED;
      state_q   <= ST_GAP;
      spawn_q   <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        col_q[i] <= col_d[i];
      end
      pat_q     <= pat_d;
      spc_cnt_q <= spc_cnt_d;
      w_cnt_q   <= w_cnt_d;
      lfsr_q    <= lfsr_d;
      state_q   <= state_d;
      spawn_q   <= spawn_d;
    end
  end

  assign pipe     = col_q[0];
  assign col_data = col_q[col_sel];
  assign spawn    = spawn_q;

endmodule

// File: tb/tb_pipe_gen.sv
// Directed bench for pipe_gen: default instance plus a GAP_H=7/PIPE_W=1 instance
// seeded so that every early LFSR value folds (c >= R).
module tb_pipe_gen;

  logic        clk;
  logic        reset;
  logic        clkP;
  logic        run;
  logic        gameover;
  logic [3:0]  col_sel;
  logic [15:0] pipe1, col_data1, pipe2, col_data2;
  logic        spawn1, spawn2;

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-computed spawn patterns, in spawn order.
  logic [15:0] tbl1 [5] = '{16'hFC3F, 16'h87FF, 16'hFC3F, 16'h87FF, 16'hFE1F};
  logic [15:0] tbl2 [4] = '{16'h80FF, 16'h80FF, 16'hC07F, 16'hE03F};

  pipe_gen u_dut1 (
    .clk(clk), .reset(reset), .clkP(clkP), .run(run), .gameover(gameover),
    .col_sel(col_sel), .pipe(pipe1), .col_data(col_data1), .spawn(spawn1)
  );

  pipe_gen #(.GAP_H(7), .PIPE_W(1), .SPACING(6), .SEED(8'h0F)) u_dut2 (
    .clk(clk), .reset(reset), .clkP(clkP), .run(run), .gameover(gameover),
    .col_sel(col_sel), .pipe(pipe2), .col_data(col_data2), .spawn(spawn2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // One pipe tick: clkP high across exactly one rising edge; returns at the next falling edge.
  task automatic tick();
    @(negedge clk);
    clkP = 1'b1;
    @(negedge clk);
    clkP = 1'b0;
  endtask

  // Column idx after t ticks, default instance (width 2, spacing 6).
  function automatic logic [15:0] model1(input int t, input int idx);
    int k;
    k = t - (15 - idx);
    if (k < 1) return 16'h0000;
    if (((k - 1) % 6) < 2) return tbl1[(k - 1) / 6];
    return 16'h0000;
  endfunction

  // Column idx after t ticks, width-1 instance.
  function automatic logic [15:0] model2(input int t, input int idx);
    int k;
    k = t - (15 - idx);
    if (k < 1) return 16'h0000;
    if (((k - 1) % 6) == 0) return tbl2[(k - 1) / 6];
    return 16'h0000;
  endfunction

  function automatic int zeros(input logic [15:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) if (!v[i]) n++;
    return n;
  endfunction

  task automatic check_field(input string tag, input int t);
    for (int i = 0; i < 16; i++) begin
      col_sel = 4'(i);
      #1;
      check($sformatf("%s_col%0d", tag, i), col_data1, model1(t, i));
    end
    check($sformatf("%s_pipe", tag), pipe1, model1(t, 0));
    col_sel = 4'd15;
  endtask

  initial begin
    reset    = 1'b0;
    clkP     = 1'b0;
    run      = 1'b0;
    gameover = 1'b0;
    col_sel  = 4'd15;

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run   = 1'b1;
    repeat (3) @(negedge clk);
    check_field("reset", 0);
    check("reset_spawn", {15'd0, spawn1}, 16'h0000);
    check("reset_pipe2", pipe2, 16'h0000);

    // Scroll the default field for 20 ticks
    for (int t = 1; t <= 20; t++) begin
      tick();
      check($sformatf("run_col15_t%0d", t), col_data1, model1(t, 15));
      check($sformatf("run_pipe_t%0d", t), pipe1, model1(t, 0));
      check($sformatf("run_spawn_t%0d", t), {15'd0, spawn1}, {15'd0, (t % 6) == 1});
      if (t == 1) begin
        @(posedge clk);
        #1;
        check("spawn_one_cycle", {15'd0, spawn1}, 16'h0000);
      end
    end

    // Freeze with gameover, then with run=0
    gameover = 1'b1;
    repeat (5) tick();
    check_field("frz_go", 20);
    check("frz_go_spawn", {15'd0, spawn1}, 16'h0000);
    gameover = 1'b0;
    run      = 1'b0;
    repeat (5) tick();
    check_field("frz_run", 20);
    run = 1'b1;
    tick();
    check_field("resume", 21);

    // Reach tick 25 (spawn, BODY pending), then reset between edges
    for (int t = 22; t <= 25; t++) tick();
    check("t25_col15", col_data1, 16'hFE1F);
    #2;
    reset = 1'b0;
    #1;
    check("mid_reset_spawn", {15'd0, spawn1}, 16'h0000);
    check("mid_reset_col15", col_data1, 16'h0000);
    check_field("mid_reset", 0);
    @(negedge clk);
    reset = 1'b1;

    // Post-reset replay on both instances
    for (int t = 1; t <= 19; t++) begin
      tick();
      check($sformatf("rst_col15_t%0d", t), col_data1, model1(t, 15));
      check($sformatf("d2_col15_t%0d", t), col_data2, model2(t, 15));
      check($sformatf("d2_pipe_t%0d", t), pipe2, model2(t, 0));
      check($sformatf("d2_spawn_t%0d", t), {15'd0, spawn2}, {15'd0, (t % 6) == 1});
      if ((t % 6) == 1) begin
        check($sformatf("d2_zeros_t%0d", t), 16'(zeros(col_data2)), 16'd7);
        check($sformatf("d2_row0_t%0d", t), {15'd0, col_data2[0]}, 16'd1);
        check($sformatf("d2_row15_t%0d", t), {15'd0, col_data2[15]}, 16'd1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
